// File: rtl/vx_mem_perf_monitor.sv
// Memory-port performance monitor: taps req/rsp handshakes of NUM_PORTS ports and keeps
// read/write/stall/latency counters, pending/peak tracking, atomic snapshot/clear and sticky flags.
module vx_mem_perf_monitor #(
   parameter int unsigned NUM_PORTS = 1,
   parameter int unsigned CTR_BITS  = 44,
   parameter int unsigned PEND_BITS = 16,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_PORTS-1:0] mem_req_valid,
   input  logic [NUM_PORTS-1:0] mem_req_ready,
   input  logic [NUM_PORTS-1:0] mem_req_rw,
   input  logic [NUM_PORTS-1:0] mem_rsp_valid,
   input  logic [NUM_PORTS-1:0] mem_rsp_ready,
   input  logic                 snap_req,
   input  logic                 snap_clear,
   output logic [CTR_BITS-1:0]  perf_reads,
   output logic [CTR_BITS-1:0]  perf_writes,
   output logic [CTR_BITS-1:0]  perf_stalls,
   output logic [CTR_BITS-1:0]  perf_latency,
   output logic [PEND_BITS-1:0] perf_pending,
   output logic [PEND_BITS-1:0] perf_max_pending,
   output logic                 perf_valid,
   output logic                 perf_ovf,
   output logic                 perf_err
);

   localparam int unsigned CNT_W  = $clog2(NUM_PORTS + 1);
   localparam int unsigned SUM_W  = ((CTR_BITS > PEND_BITS) ? CTR_BITS : PEND_BITS) + 1;
   localparam int unsigned PSUM_W = PEND_BITS + 2;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PORTS-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Returns {overflow, next value}; the increment may be wider than the counter (latency).
   function automatic logic [CTR_BITS:0] ctr_add(input logic [CTR_BITS-1:0] cur,
                                                 input logic [SUM_W-1:0]    inc);
      logic [SUM_W-1:0] sum;
      logic             ovf;
      sum = SUM_W'(cur) + inc;
      ovf = |(sum >> CTR_BITS);
      if (ovf && SATURATE) begin
         return {1'b1, {CTR_BITS{1'b1}}};
      end else begin
         return {ovf, sum[CTR_BITS-1:0]};
      end
   endfunction

   logic [CNT_W-1:0]     rd_cnt, wr_cnt, st_cnt, rs_cnt;
   logic [PSUM_W-1:0]    pend_sum;
   logic                 pend_under, pend_ovf, clear_now;
   logic [CTR_BITS:0]    reads_add, writes_add, stalls_add, lat_add;
   logic                 ctr_ovf;

   logic [CTR_BITS-1:0]  reads_q, writes_q, stalls_q, lat_q;
   logic [CTR_BITS-1:0]  reads_upd, writes_upd, stalls_upd, lat_upd;
   logic [CTR_BITS-1:0]  reads_d, writes_d, stalls_d, lat_d;
   logic [PEND_BITS-1:0] pending_q, pending_d, max_q, max_upd, max_d;
   logic                 ovf_q, ovf_d, err_q, err_d;

   logic [CTR_BITS-1:0]  snap_reads_q, snap_writes_q, snap_stalls_q, snap_lat_q;
   logic [PEND_BITS-1:0] snap_max_q;
   logic                 valid_q;

   assign rd_cnt    = popcount(mem_req_valid & mem_req_ready & ~mem_req_rw);
   assign wr_cnt    = popcount(mem_req_valid & mem_req_ready &  mem_req_rw);
   assign st_cnt    = popcount(mem_req_valid & ~mem_req_ready);
   assign rs_cnt    = popcount(mem_rsp_valid & mem_rsp_ready);
   assign clear_now = snap_req & snap_clear;

   // Pending-read tracking with underflow/overflow detection (independent of enable).
   always_comb begin
      pend_sum   = PSUM_W'(pending_q) + PSUM_W'(rd_cnt) - PSUM_W'(rs_cnt);
      pend_under = pend_sum[PSUM_W-1];
      pend_ovf   = ~pend_sum[PSUM_W-1] & pend_sum[PEND_BITS];
      if (pend_under) begin
         pending_d = '0;
      end else if (pend_ovf) begin
         pending_d = '1;
      end else begin
         pending_d = pend_sum[PEND_BITS-1:0];
      end
   end

   // Event counters: updated values feed the snapshot, a coincident clear zeroes the live copy.
   always_comb begin
      reads_add  = ctr_add(reads_q,  SUM_W'(rd_cnt));
      writes_add = ctr_add(writes_q, SUM_W'(wr_cnt));
      stalls_add = ctr_add(stalls_q, SUM_W'(st_cnt));
      lat_add    = ctr_add(lat_q,    SUM_W'(pending_q));
      reads_upd  = reads_q;
      writes_upd = writes_q;
      stalls_upd = stalls_q;
      lat_upd    = lat_q;
      max_upd    = max_q;
      ctr_ovf    = 1'b0;
      if (enable) begin
         reads_upd  = reads_add[CTR_BITS-1:0];
         writes_upd = writes_add[CTR_BITS-1:0];
         stalls_upd = stalls_add[CTR_BITS-1:0];
         lat_upd    = lat_add[CTR_BITS-1:0];
         ctr_ovf    = reads_add[CTR_BITS] | writes_add[CTR_BITS] |
                      stalls_add[CTR_BITS] | lat_add[CTR_BITS];
         max_upd    = (pending_d > max_q) ? pending_d : max_q;
      end else begin
         ctr_ovf    = 1'b0;
      end
      err_d = err_q | pend_under;
      if (clear_now) begin
         reads_d  = '0;
         writes_d = '0;
         stalls_d = '0;
         lat_d    = '0;
         max_d    = pending_d;
         ovf_d    = 1'b0;
      end else begin
         reads_d  = reads_upd;
         writes_d = writes_upd;
         stalls_d = stalls_upd;
         lat_d    = lat_upd;
         max_d    = max_upd;
         ovf_d    = ovf_q | ctr_ovf | pend_ovf;
      end
   end

   // Live state, snapshot registers and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reads_q       <= '0;
         writes_q      <= '0;
         stalls_q      <= '0;
         lat_q         <= '0;
         pending_q     <= '0;
         max_q         <= '0;
         ovf_q         <= 1'b0;
         err_q         <= 1'b0;
         snap_reads_q  <= '0;
         snap_writes_q <= '0;
         snap_stalls_q <= '0;
         snap_lat_q    <= '0;
         snap_max_q    <= '0;
         valid_q       <= 1'b0;
      end else begin
         reads_q   <= reads_d;
         writes_q  <= writes_d;
         stalls_q  <= stalls_d;
         lat_q     <= lat_d;
         pending_q <= pending_d;
         max_q     <= max_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         valid_q   <= snap_req;
         if (snap_req) begin
            snap_reads_q  <= reads_upd;
            snap_writes_q <= writes_upd;
            snap_stalls_q <= stalls_upd;
            snap_lat_q    <= lat_upd;
            snap_max_q    <= max_upd;
         end
      end
   end

   assign perf_reads       = snap_reads_q;
   assign perf_writes      = snap_writes_q;
   assign perf_stalls      = snap_stalls_q;
   assign perf_latency     = snap_lat_q;
   assign perf_pending     = pending_q;
   assign perf_max_pending = snap_max_q;
   assign perf_valid       = valid_q;
   assign perf_ovf         = ovf_q;
   assign perf_err         = err_q;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Bench for vx_mem_perf_monitor: a 4-port wide-counter instance checked against a cycle model
// via an expected-snapshot queue, plus 4-bit saturating and wrapping instances.
module tb_vx_mem_perf_monitor;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-port, 44-bit counters, wrapping
   logic        en, snap, clr;
   logic [3:0]  rv, rr, rw, sv, sr;
   logic [43:0] o_reads, o_writes, o_stalls, o_lat;
   logic [15:0] o_pend, o_max;
   logic        o_valid, o_ovf, o_err;

   // shared inputs for the 4-bit saturating (a) and wrapping (b) instances
   logic        s_en, s_snap, s_clr;
   logic [3:0]  s_rv;
   logic [3:0]  a_reads, a_writes, a_stalls, a_lat, b_reads, b_writes, b_stalls, b_lat;
   logic [15:0] a_pend, a_max, b_pend, b_max;
   logic        a_valid, a_ovf, a_err, b_valid, b_ovf, b_err;

   vx_mem_perf_monitor #(.NUM_PORTS(4), .CTR_BITS(44), .PEND_BITS(16), .SATURATE(1'b0)) dut (
      .clk(clk), .reset(reset), .enable(en),
      .mem_req_valid(rv), .mem_req_ready(rr), .mem_req_rw(rw),
      .mem_rsp_valid(sv), .mem_rsp_ready(sr),
      .snap_req(snap), .snap_clear(clr),
      .perf_reads(o_reads), .perf_writes(o_writes), .perf_stalls(o_stalls),
      .perf_latency(o_lat), .perf_pending(o_pend), .perf_max_pending(o_max),
      .perf_valid(o_valid), .perf_ovf(o_ovf), .perf_err(o_err));

   vx_mem_perf_monitor #(.NUM_PORTS(4), .CTR_BITS(4), .PEND_BITS(16), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .enable(s_en),
      .mem_req_valid(s_rv), .mem_req_ready(s_rv), .mem_req_rw(4'b0000),
      .mem_rsp_valid(4'b0000), .mem_rsp_ready(4'b0000),
      .snap_req(s_snap), .snap_clear(s_clr),
      .perf_reads(a_reads), .perf_writes(a_writes), .perf_stalls(a_stalls),
      .perf_latency(a_lat), .perf_pending(a_pend), .perf_max_pending(a_max),
      .perf_valid(a_valid), .perf_ovf(a_ovf), .perf_err(a_err));

   vx_mem_perf_monitor #(.NUM_PORTS(4), .CTR_BITS(4), .PEND_BITS(16), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(s_en),
      .mem_req_valid(s_rv), .mem_req_ready(s_rv), .mem_req_rw(4'b0000),
      .mem_rsp_valid(4'b0000), .mem_rsp_ready(4'b0000),
      .snap_req(s_snap), .snap_clear(s_clr),
      .perf_reads(b_reads), .perf_writes(b_writes), .perf_stalls(b_stalls),
      .perf_latency(b_lat), .perf_pending(b_pend), .perf_max_pending(b_max),
      .perf_valid(b_valid), .perf_ovf(b_ovf), .perf_err(b_err));

   typedef struct {
      logic [43:0] reads, writes, stalls, lat;
      logic [15:0] maxp;
   } snap_t;

   snap_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [43:0] m_reads, m_writes, m_stalls, m_lat;
   int          m_pend, m_max;
   logic        m_err;

   task automatic model_reset();
      m_reads = '0; m_writes = '0; m_stalls = '0; m_lat = '0;
      m_pend = 0; m_max = 0; m_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      rv = '0; rr = '0; rw = '0; sv = '0; sr = '0; snap = 1'b0; clr = 1'b0;
      s_rv = '0; s_snap = 1'b0; s_clr = 1'b0;
   endtask

   // One cycle on the wide instance: drive, advance the model, then check after the edge.
   task automatic step(input logic [3:0] v, input logic [3:0] r, input logic [3:0] w,
                       input logic [3:0] pv, input logic [3:0] pr,
                       input logic sn, input logic cl);
      int    rd, wr, st, rs, np;
      snap_t e, got;
      rv = v; rr = r; rw = w; sv = pv; sr = pr; snap = sn; clr = cl;
      rd = $countones(v & r & ~w);
      wr = $countones(v & r & w);
      st = $countones(v & ~r);
      rs = $countones(pv & pr);
      np = m_pend + rd - rs;
      if (np < 0) begin
         np = 0;
         m_err = 1'b1;
      end
      if (en) begin
         m_reads  = m_reads + 44'(rd);
         m_writes = m_writes + 44'(wr);
         m_stalls = m_stalls + 44'(st);
         m_lat    = m_lat + 44'(m_pend);
         if (np > m_max) m_max = np;
      end
      if (sn) begin
         e.reads = m_reads; e.writes = m_writes; e.stalls = m_stalls;
         e.lat = m_lat; e.maxp = 16'(m_max);
         exp_q.push_back(e);
         if (cl) begin
            m_reads = '0; m_writes = '0; m_stalls = '0; m_lat = '0; m_max = np;
         end
      end
      m_pend = np;
      @(posedge clk); #1;
      checks++;
      if (o_pend !== 16'(m_pend)) begin
         errors++; $display("FAIL pending: got %0d want %0d", o_pend, m_pend);
      end
      checks++;
      if (o_err !== m_err) begin
         errors++; $display("FAIL err_flag: got %0b want %0b", o_err, m_err);
      end
      checks++;
      if (o_valid !== sn) begin
         errors++; $display("FAIL valid_pulse: got %0b want %0b", o_valid, sn);
      end
      if (o_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_snapshot: got valid want no snapshot");
         end else begin
            got = exp_q.pop_front();
            if (o_reads !== got.reads || o_writes !== got.writes || o_stalls !== got.stalls ||
                o_lat !== got.lat || o_max !== got.maxp) begin
               errors++;
               $display("FAIL snapshot: got r%0d w%0d s%0d l%0d m%0d want r%0d w%0d s%0d l%0d m%0d",
                        o_reads, o_writes, o_stalls, o_lat, o_max,
                        got.reads, got.writes, got.stalls, got.lat, got.maxp);
            end
         end
      end
   endtask

   task automatic idle_step(input logic sn, input logic cl);
      step(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, sn, cl);
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({o_reads, o_writes, o_stalls, o_lat, o_pend, o_max, o_valid, o_ovf, o_err} !== '0 ||
          {a_reads, a_lat, a_valid, a_ovf, b_reads, b_lat, b_valid, b_ovf} !== '0) begin
         errors++;
         $display("FAIL %s: got r%0d l%0d p%0d v%0b o%0b e%0b ar%0d br%0d want all 0", tag,
                  o_reads, o_lat, o_pend, o_valid, o_ovf, o_err, a_reads, b_reads);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; s_en = 1'b1;
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset_state");
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("after_release");
   endtask

   task automatic test_idle_snapshot();
      idle_step(1'b1, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_read_latency();
      step(4'b0111, 4'b0111, 4'b0000, 4'b0, 4'b0, 1'b0, 1'b0);
      repeat (4) idle_step(1'b0, 1'b0);
      step(4'b0, 4'b0, 4'b0, 4'b0111, 4'b0111, 1'b0, 1'b0);
      idle_step(1'b1, 1'b1);
   endtask

   task automatic test_stalls();
      repeat (7) step(4'b0010, 4'b0000, 4'b0010, 4'b0, 4'b0, 1'b0, 1'b0);
      step(4'b0010, 4'b0010, 4'b0010, 4'b0, 4'b0, 1'b0, 1'b0);
      idle_step(1'b1, 1'b1);
   endtask

   task automatic test_mixed();
      step(4'b1111, 4'b1011, 4'b1000, 4'b0, 4'b0, 1'b0, 1'b0);
      step(4'b0101, 4'b0101, 4'b0100, 4'b0001, 4'b0001, 1'b1, 1'b0);
      en = 1'b0;
      step(4'b1111, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      step(4'b0, 4'b0, 4'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
      en = 1'b1;
      step(4'b0, 4'b0, 4'b0, 4'b1111, 4'b1111, 1'b1, 1'b1);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      step(4'b0011, 4'b0011, 4'b0000, 4'b0, 4'b0, 1'b1, 1'b1);
      idle_step(1'b1, 1'b0);
      step(4'b0, 4'b0, 4'b0, 4'b0011, 4'b0011, 1'b1, 1'b0);
      idle_step(1'b1, 1'b1);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_underflow();
      step(4'b0, 4'b0, 4'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
      idle_step(1'b1, 1'b1);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_saturate();
      s_en = 1'b1; s_rv = 4'b0001;
      repeat (20) @(posedge clk);
      #1 s_rv = 4'b0000; s_snap = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b1 || a_reads !== 4'd15 || a_lat !== 4'd15 || a_ovf !== 1'b1 ||
          a_pend !== 16'd20 || a_max !== 16'd20) begin
         errors++;
         $display("FAIL sat_snapshot: got v%0b r%0d l%0d o%0b p%0d m%0d want 1 15 15 1 20 20",
                  a_valid, a_reads, a_lat, a_ovf, a_pend, a_max);
      end
      checks++;
      if (b_valid !== 1'b1 || b_reads !== 4'd4 || b_lat !== 4'd2 || b_ovf !== 1'b1) begin
         errors++;
         $display("FAIL wrap_snapshot: got v%0b r%0d l%0d o%0b want 1 4 2 1",
                  b_valid, b_reads, b_lat, b_ovf);
      end
      s_en = 1'b0; s_clr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_reads !== 4'd15 || b_reads !== 4'd4 || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
         errors++;
         $display("FAIL clear_snapshot: got ar%0d br%0d ao%0b bo%0b want 15 4 0 0",
                  a_reads, b_reads, a_ovf, b_ovf);
      end
      s_clr = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (a_reads !== 4'd0 || a_lat !== 4'd0 || b_reads !== 4'd0 || a_ovf !== 1'b0 ||
          a_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_clear: got ar%0d al%0d br%0d ao%0b av%0b want 0 0 0 0 1",
                  a_reads, a_lat, b_reads, a_ovf, a_valid);
      end
      s_snap = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
         errors++; $display("FAIL valid_drop: got %0b %0b want 0 0", a_valid, b_valid);
      end
   endtask

   task automatic test_async_reset();
      step(4'b0111, 4'b0111, 4'b0000, 4'b0, 4'b0, 1'b1, 1'b0);
      rv = 4'b0011; rr = 4'b0011; snap = 1'b1;
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      @(posedge clk); #1;
      check_all_zero("held_reset");
      idle_inputs();
      model_reset();
      #2 reset = 1'b1;
      @(posedge clk); #1;
      idle_step(1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_snapshot();
      test_read_latency();
      test_stalls();
      test_mixed();
      test_back_to_back();
      test_underflow();
      test_saturate();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL missing_snapshots: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
